// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one main_memory port
// between two cache-side requesters (I-cache / D-cache).
// Ports: clock, reset (async, active-high);
//   req0_*/resp0_*, req1_*/resp1_* : requester msg/address/data buses;
//   mem_* : request to memory; mem_resp_* : response from memory;
//   grant : one-hot port owner (00 idle); busy : transaction in flight.
// Optional MEM_ARB_PERF_EN adds grant_count0/1 and conflict_count.
module mem_port_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 12,
   parameter int MSG_BITS     = 3
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [MSG_BITS-1:0]     req0_msg,
   input  logic [ADDRESS_BITS-1:0] req0_address,
   input  logic [DATA_WIDTH-1:0]   req0_data,
   output logic [MSG_BITS-1:0]     resp0_msg,
   output logic [ADDRESS_BITS-1:0] resp0_address,
   output logic [DATA_WIDTH-1:0]   resp0_data,
   input  logic [MSG_BITS-1:0]     req1_msg,
   input  logic [ADDRESS_BITS-1:0] req1_address,
   input  logic [DATA_WIDTH-1:0]   req1_data,
   output logic [MSG_BITS-1:0]     resp1_msg,
   output logic [ADDRESS_BITS-1:0] resp1_address,
   output logic [DATA_WIDTH-1:0]   resp1_data,
   output logic [MSG_BITS-1:0]     mem_msg,
   output logic [ADDRESS_BITS-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]   mem_data,
   input  logic [MSG_BITS-1:0]     mem_resp_msg,
   input  logic [ADDRESS_BITS-1:0] mem_resp_address,
   input  logic [DATA_WIDTH-1:0]   mem_resp_data,
`ifdef MEM_ARB_PERF_EN
   output logic [31:0]             grant_count0,
   output logic [31:0]             grant_count1,
   output logic [31:0]             conflict_count,
`endif
   output logic [1:0]              grant,
   output logic                    busy
);

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

   state_t                  state, state_n;
   logic                    ptr, ptr_n;
   logic [MSG_BITS-1:0]     mem_msg_n;
   logic [ADDRESS_BITS-1:0] mem_address_n;
   logic [DATA_WIDTH-1:0]   mem_data_n;
   logic [MSG_BITS-1:0]     resp0_msg_n, resp1_msg_n;
   logic [ADDRESS_BITS-1:0] resp0_address_n, resp1_address_n;
   logic [DATA_WIDTH-1:0]   resp0_data_n, resp1_data_n;
   logic [1:0]              grant_n;
   logic                    busy_n;
   logic                    pend0, pend1, win1, accept;

   assign pend0 = (req0_msg != '0);
   assign pend1 = (req1_msg != '0);
   // port 1 wins when alone, or on a tie when the pointer names it
   assign win1 = pend1 && (!pend0 || ptr);
   // only a response for the latched address ends the transaction
   assign accept = (mem_resp_msg != '0) &&
                   (mem_resp_address == mem_address);

   always_comb begin
      state_n         = state;
      ptr_n           = ptr;
      mem_msg_n       = mem_msg;
      mem_address_n   = mem_address;
      mem_data_n      = mem_data;
      resp0_msg_n     = '0;
      resp0_address_n = '0;
      resp0_data_n    = '0;
      resp1_msg_n     = '0;
      resp1_address_n = '0;
      resp1_data_n    = '0;
      grant_n         = grant;
      busy_n          = busy;
      unique case (state)
         IDLE: begin
            if (pend0 || pend1) begin
               mem_msg_n     = win1 ? req1_msg : req0_msg;
               mem_address_n = win1 ? req1_address : req0_address;
               mem_data_n    = win1 ? req1_data : req0_data;
               grant_n       = win1 ? 2'b10 : 2'b01;
               busy_n        = 1'b1;
               state_n       = BUSY;
            end
         end
         BUSY: begin
            if (accept) begin
               if (grant[1]) begin
                  resp1_msg_n     = mem_resp_msg;
                  resp1_address_n = mem_resp_address;
                  resp1_data_n    = mem_resp_data;
               end else begin
                  resp0_msg_n     = mem_resp_msg;
                  resp0_address_n = mem_resp_address;
                  resp0_data_n    = mem_resp_data;
               end
               mem_msg_n = '0;
               state_n   = RELEASE;
            end
         end
         RELEASE: begin
            grant_n = 2'b00;
            busy_n  = 1'b0;
            // hand priority to the port that was not just served
            ptr_n   = grant[0];
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         ptr           <= 1'b0;
         mem_msg       <= '0;
         mem_address   <= '0;
         mem_data      <= '0;
         resp0_msg     <= '0;
         resp0_address <= '0;
         resp0_data    <= '0;
         resp1_msg     <= '0;
         resp1_address <= '0;
         resp1_data    <= '0;
         grant         <= '0;
         busy          <= 1'b0;
      end else begin
         state         <= state_n;
         ptr           <= ptr_n;
         mem_msg       <= mem_msg_n;
         mem_address   <= mem_address_n;
         mem_data      <= mem_data_n;
         resp0_msg     <= resp0_msg_n;
         resp0_address <= resp0_address_n;
         resp0_data    <= resp0_data_n;
         resp1_msg     <= resp1_msg_n;
         resp1_address <= resp1_address_n;
         resp1_data    <= resp1_data_n;
         grant         <= grant_n;
         busy          <= busy_n;
      end
   end

`ifdef MEM_ARB_PERF_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         grant_count0   <= '0;
         grant_count1   <= '0;
         conflict_count <= '0;
      end else if (state == IDLE) begin
         if (pend0 && !win1 && grant_count0 != '1)
            grant_count0 <= grant_count0 + 32'd1;
         if (win1 && grant_count1 != '1)
            grant_count1 <= grant_count1 + 32'd1;
         if (pend0 && pend1 && conflict_count != '1)
            conflict_count <= conflict_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed + randomized check of mem_port_arbiter
// against a transaction-level model kept in the bench.
module tb_mem_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 12;
   localparam int MW = 3;

   logic          clock = 1'b0;
   logic          reset;
   logic [MW-1:0] req0_msg, req1_msg, resp0_msg, resp1_msg;
   logic [AW-1:0] req0_address, req1_address;
   logic [AW-1:0] resp0_address, resp1_address;
   logic [DW-1:0] req0_data, req1_data, resp0_data, resp1_data;
   logic [MW-1:0] mem_msg, mem_resp_msg;
   logic [AW-1:0] mem_address, mem_resp_address;
   logic [DW-1:0] mem_data, mem_resp_data;
   logic [1:0]    grant;
   logic          busy;
`ifdef MEM_ARB_PERF_EN
   logic [31:0]   grant_count0, grant_count1, conflict_count;
`endif

   always #5 clock = ~clock;

   mem_port_arbiter #(
      .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .MSG_BITS(MW)
   ) dut (
      .clock(clock), .reset(reset),
      .req0_msg(req0_msg), .req0_address(req0_address),
      .req0_data(req0_data),
      .resp0_msg(resp0_msg), .resp0_address(resp0_address),
      .resp0_data(resp0_data),
      .req1_msg(req1_msg), .req1_address(req1_address),
      .req1_data(req1_data),
      .resp1_msg(resp1_msg), .resp1_address(resp1_address),
      .resp1_data(resp1_data),
      .mem_msg(mem_msg), .mem_address(mem_address),
      .mem_data(mem_data),
      .mem_resp_msg(mem_resp_msg),
      .mem_resp_address(mem_resp_address),
      .mem_resp_data(mem_resp_data),
`ifdef MEM_ARB_PERF_EN
      .grant_count0(grant_count0), .grant_count1(grant_count1),
      .conflict_count(conflict_count),
`endif
      .grant(grant), .busy(busy)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // transaction-level model: who owns the port, what was latched,
   // whether the answer has been delivered, who has priority next
   int            m_owner;
   bit            m_done;
   bit            m_ptr;
   logic [MW-1:0] m_lmsg;
   logic [AW-1:0] m_laddr;
   logic [DW-1:0] m_ldata;
   logic [MW-1:0] e_mem_msg;
   logic [1:0]    e_grant;
   bit            e_busy;
   logic [MW-1:0] e_rmsg [2];
   logic [AW-1:0] e_raddr [2];
   logic [DW-1:0] e_rdata [2];
   logic [31:0]   m_gc0, m_gc1, m_conf;
   int            mdly;
   bit            rr_mode = 1'b0;

   task automatic model_reset();
      m_owner = -1; m_done = 1'b0; m_ptr = 1'b0;
      m_lmsg = '0; m_laddr = '0; m_ldata = '0;
      e_mem_msg = '0; e_grant = '0; e_busy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         e_rmsg[i] = '0; e_raddr[i] = '0; e_rdata[i] = '0;
      end
      m_gc0 = '0; m_gc1 = '0; m_conf = '0;
      mdly = 0;
   endtask

   task automatic model_step();
      bit p0, p1;
      int w;
      for (int i = 0; i < 2; i++) begin
         e_rmsg[i] = '0; e_raddr[i] = '0; e_rdata[i] = '0;
      end
      if (m_owner < 0) begin
         p0 = (req0_msg != '0);
         p1 = (req1_msg != '0);
         if (p0 && p1) m_conf++;
         if (p0 || p1) begin
            w = (p0 && p1) ? int'(m_ptr) : (p0 ? 0 : 1);
            m_lmsg  = (w == 0) ? req0_msg : req1_msg;
            m_laddr = (w == 0) ? req0_address : req1_address;
            m_ldata = (w == 0) ? req0_data : req1_data;
            e_mem_msg = m_lmsg;
            e_grant = (w == 0) ? 2'b01 : 2'b10;
            e_busy = 1'b1;
            m_owner = w;
            if (w == 0) m_gc0++; else m_gc1++;
            mdly = $urandom_range(0, 4);
         end
      end else if (!m_done) begin
         if (mem_resp_msg != '0 && mem_resp_address == m_laddr) begin
            e_rmsg[m_owner]  = mem_resp_msg;
            e_raddr[m_owner] = mem_resp_address;
            e_rdata[m_owner] = mem_resp_data;
            e_mem_msg = '0;
            m_done = 1'b1;
         end
      end else begin
         e_grant = 2'b00;
         e_busy = 1'b0;
         m_ptr = (m_owner == 0);
         m_owner = -1;
         m_done = 1'b0;
      end
   endtask

   task automatic compare();
      chk("grant", grant, e_grant);
      chk("busy", busy, e_busy);
      chk("mem_msg", mem_msg, e_mem_msg);
      if (e_mem_msg != '0) begin
         chk("mem_address", mem_address, m_laddr);
         chk("mem_data", mem_data, m_ldata);
      end
      chk("resp0_msg", resp0_msg, e_rmsg[0]);
      chk("resp0_address", resp0_address, e_raddr[0]);
      chk("resp0_data", resp0_data, e_rdata[0]);
      chk("resp1_msg", resp1_msg, e_rmsg[1]);
      chk("resp1_address", resp1_address, e_raddr[1]);
      chk("resp1_data", resp1_data, e_rdata[1]);
`ifdef MEM_ARB_PERF_EN
      chk("grant_count0", grant_count0, m_gc0);
      chk("grant_count1", grant_count1, m_gc1);
      chk("conflict_count", conflict_count, m_conf);
`endif
   endtask

   // advance to the next falling edge, update model, check outputs
   task automatic cycle();
      @(negedge clock);
      if (!reset) model_step();
      compare();
   endtask

   task automatic set_req(input int p, input logic [MW-1:0] m,
                          input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      if (p == 0) begin
         req0_msg = m; req0_address = a; req0_data = d;
      end else begin
         req1_msg = m; req1_address = a; req1_data = d;
      end
   endtask

   task automatic set_mem(input logic [MW-1:0] m,
                          input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      mem_resp_msg = m; mem_resp_address = a; mem_resp_data = d;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_req(0, '0, '0, '0);
      set_req(1, '0, '0, '0);
      set_mem('0, '0, '0);
      #1;
      model_reset();
      chk("rst_grant", grant, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_mem_msg", mem_msg, 3'd0);
      chk("rst_resp0_msg", resp0_msg, 3'd0);
      chk("rst_resp1_msg", resp1_msg, 3'd0);
      cycle();
      reset = 1'b0;
   endtask

   task automatic rand_drive();
      logic [MW-1:0] cm;
      for (int i = 0; i < 2; i++) begin
         cm = (i == 0) ? req0_msg : req1_msg;
         if (e_rmsg[i] != '0)
            set_req(i, '0, '0, '0);
         else if (cm == '0) begin
            if (rr_mode || $urandom_range(0, 2) == 0)
               set_req(i, MW'($urandom_range(1, 7)),
                       AW'($urandom), $urandom);
         end else if ($urandom_range(0, 3) == 0)
            set_req(i, cm, AW'($urandom), $urandom);
      end
      if (m_owner >= 0 && !m_done) begin
         if (mdly > 0) begin
            mdly--;
            if ($urandom_range(0, 2) == 0)
               set_mem(MW'($urandom_range(1, 7)),
                       m_laddr ^ AW'(4), $urandom);
            else
               set_mem('0, AW'($urandom), $urandom);
         end else
            set_mem(MW'($urandom_range(1, 7)), m_laddr, $urandom);
      end else begin
         if ($urandom_range(0, 1) == 0)
            set_mem('0, AW'($urandom), $urandom);
         else
            set_mem(MW'($urandom_range(1, 7)), AW'($urandom), $urandom);
      end
   endtask

   task automatic xact(input int p, input logic [MW-1:0] m,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int dly);
      set_req(p, m, a, d);
      set_mem('0, '0, '0);
      cycle();
      repeat (dly) cycle();
      set_mem(3'd2, a, ~d);
      cycle();
      set_req(p, '0, '0, '0);
      set_mem('0, '0, '0);
      cycle();
   endtask

   logic [1:0] rr_exp [6] = '{2'b01, 2'b10, 2'b01,
                              2'b10, 2'b01, 2'b10};

   initial begin
      logic [1:0] prev;
      int n;
      reset = 1'b0;
      set_req(0, '0, '0, '0);
      set_req(1, '0, '0, '0);
      set_mem('0, '0, '0);
      model_reset();
      #2;
      do_reset();

      // single read, memory answers three cycles after the grant
      set_req(0, 3'd1, 12'h040, 32'h0);
      cycle();
      chk("rd_grant", grant, 2'b01);
      chk("rd_mem_addr", mem_address, 12'h040);
      cycle();
      cycle();
      set_mem(3'd2, 12'h040, 32'hDEADBEEF);
      cycle();
      chk("rd_resp0_msg", resp0_msg, 3'd2);
      chk("rd_resp0_addr", resp0_address, 12'h040);
      chk("rd_resp0_data", resp0_data, 32'hDEADBEEF);
      chk("rd_resp1_msg", resp1_msg, 3'd0);
      chk("rd_busy_rel", busy, 1'b1);
      set_req(0, '0, '0, '0);
      set_mem('0, '0, '0);
      cycle();
      chk("rd_resp0_clr", resp0_msg, 3'd0);
      chk("rd_grant_clr", grant, 2'b00);

      // simultaneous requests right after reset
      do_reset();
      set_req(0, 3'd1, 12'h010, 32'h1);
      set_req(1, 3'd1, 12'h020, 32'h2);
      cycle();
      chk("sim_grant0", grant, 2'b01);
      chk("sim_addr0", mem_address, 12'h010);
      set_mem(3'd2, 12'h010, 32'hA);
      cycle();
      chk("sim_resp0", resp0_msg, 3'd2);
      set_req(0, '0, '0, '0);
      set_mem('0, '0, '0);
      cycle();
      chk("sim_gap", grant, 2'b00);
      cycle();
      chk("sim_grant1", grant, 2'b10);
      chk("sim_addr1", mem_address, 12'h020);
      set_mem(3'd2, 12'h020, 32'hB);
      cycle();
      chk("sim_resp1", resp1_msg, 3'd2);
      set_req(1, '0, '0, '0);
      set_mem('0, '0, '0);
      cycle();
`ifdef MEM_ARB_PERF_EN
      chk("perf_gc0", grant_count0, 32'd1);
      chk("perf_gc1", grant_count1, 32'd1);
      chk("perf_conf", conflict_count >= 32'd1, 1'b1);
`endif

      // round robin with both ports always re-requesting
      rr_mode = 1'b1;
      prev = 2'b00;
      n = 0;
      for (int c = 0; c < 300 && n < 6; c++) begin
         cycle();
         if (prev == 2'b00 && grant != 2'b00) begin
            chk($sformatf("rr_grant%0d", n), grant, rr_exp[n]);
            n++;
         end
         prev = grant;
         rand_drive();
      end
      chk("rr_count", n, 6);
      rr_mode = 1'b0;

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         cycle();
         rand_drive();
      end

      // stray response is dropped
      do_reset();
      set_req(0, 3'd1, 12'h100, 32'h0);
      cycle();
      set_mem(3'd2, 12'h104, 32'h5555);
      cycle();
      chk("stray_busy", busy, 1'b1);
      chk("stray_resp0", resp0_msg, 3'd0);
      chk("stray_grant", grant, 2'b01);
      set_mem('0, '0, '0);
      cycle();
      set_mem(3'd2, 12'h100, 32'hCAFEF00D);
      cycle();
      chk("stray_done_msg", resp0_msg, 3'd2);
      chk("stray_done_data", resp0_data, 32'hCAFEF00D);
      set_req(0, '0, '0, '0);
      set_mem('0, '0, '0);
      cycle();

      // write pass-through, requester inputs toggle while busy
      set_req(1, 3'd3, 12'h7FC, 32'h12345678);
      cycle();
      chk("wr_grant", grant, 2'b10);
      chk("wr_msg", mem_msg, 3'd3);
      for (int k = 0; k < 3; k++) begin
         req1_data = $urandom;
         req1_address = AW'($urandom);
         cycle();
         chk("wr_hold_data", mem_data, 32'h12345678);
         chk("wr_hold_addr", mem_address, 12'h7FC);
         chk("wr_hold_msg", mem_msg, 3'd3);
      end
      set_mem(3'd4, 12'h7FC, 32'h0);
      cycle();
      chk("wr_resp1", resp1_msg, 3'd4);
      chk("wr_resp0", resp0_msg, 3'd0);
      set_req(1, '0, '0, '0);
      set_mem('0, '0, '0);
      cycle();

      // reset while port 1 owns the port with priority on port 1
      xact(0, 3'd1, 12'h200, 32'h77, 1);
      set_req(1, 3'd1, 12'h300, 32'h88);
      cycle();
      chk("mid_grant1", grant, 2'b10);
      cycle();
      do_reset();
      set_req(0, 3'd1, 12'h400, 32'h1);
      set_req(1, 3'd1, 12'h500, 32'h2);
      cycle();
      chk("mid_after_grant", grant, 2'b01);
      set_mem(3'd2, 12'h400, 32'h3);
      cycle();
      set_req(0, '0, '0, '0);
      set_req(1, '0, '0, '0);
      set_mem('0, '0, '0);
      repeat (4) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one `main_memory` port between two cache-side requesters, normally the I-cache and D-cache memory interfaces of a `RISC_V_Core`. This lets a single-ported main memory serve both caches. Each transaction is a single request/response exchange using the codebase's 3-bit msg/address/data bus. The block grants one requester at a time with round-robin priority, forwards its request, routes the response back to that requester only, and then releases the port.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDRESS_BITS, 12, address bus width
- MSG_BITS, 3, msg field width
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req0_msg  in  MSG_BITS  requester 0 request; 0 = NO_REQ
- req0_address  in  ADDRESS_BITS  requester 0 address
- req0_data  in  DATA_WIDTH  requester 0 write data
- resp0_msg  out  MSG_BITS  response msg to requester 0; 0 = none
- resp0_address  out  ADDRESS_BITS  response address to requester 0
- resp0_data  out  DATA_WIDTH  response data to requester 0
- req1_* / resp1_*  same set and widths as above, for requester 1
- mem_msg  out  MSG_BITS  request msg to memory port
- mem_address  out  ADDRESS_BITS  request address to memory port
- mem_data  out  DATA_WIDTH  request data to memory port
- mem_resp_msg  in  MSG_BITS  memory response msg; 0 = none
- mem_resp_address  in  ADDRESS_BITS  memory response address
- mem_resp_data  in  DATA_WIDTH  memory response data
- grant  out  2  one-hot owner of the port; 00 when idle
- busy  out  1  high in BUSY and RELEASE

## Operation
- States: IDLE, BUSY, RELEASE. All outputs are registered.
- Reset (async):
  - state = IDLE, priority pointer = 0.
  - All mem_*, resp*_*, grant and busy = 0.
  - Any in-flight memory transaction is abandoned with no response delivered.
- IDLE, choosing a winner:
  - A requester is pending when its req_msg != 0.
  - If only one is pending, it wins.
  - If both are pending, the port named by the pointer wins.
- IDLE, on a winner:
  - Load mem_msg, mem_address and mem_data from the winner.
  - Set grant to the winner; go to BUSY.
- BUSY:
  - mem_* stays held at the latched values. Changes on the granted req inputs are ignored.
  - The non-granted requester is fully stalled: its resp stays 0.
  - A response is accepted when mem_resp_msg != 0 and mem_resp_address == latched address.
  - A response with a mismatched address is dropped; the block stays in BUSY.
- On an accepted response:
  - Copy mem_resp_msg, mem_resp_address and mem_resp_data into the granted resp*_*.
  - mem_msg = 0; go to RELEASE.
- RELEASE:
  - resp*_* returns to 0.
  - grant = 00; pointer = the other port; go to IDLE.
- Requester contract: drop req_msg to 0 in the cycle its resp_msg is non-zero. A request still held in IDLE is treated as a new request.
- Any non-zero msg value is forwarded verbatim in both directions; the block does not decode opcodes.

## Timing
- Request present before edge N → mem_* and grant valid after edge N.
- Accepted response at edge M → resp*_* valid for exactly one cycle (M to M+1). mem_msg = 0 after edge M.
- After edge M+1 the state is IDLE; the earliest next grant is edge M+2.
- The memory port therefore sees at least 2 cycles of mem_msg = 0 between back-to-back transactions.
- Both requesters arrive in the same cycle → the pointer holder is served first and the other is served immediately after.
- No requester waits more than one foreign transaction.
- Response arriving in the same cycle as the request is launched (edge N) is not possible and is ignored.
- reset asserted in BUSY → outputs clear immediately, without waiting for a clock edge.

## Configuration
- MEM_ARB_PERF_EN defined adds the following 32-bit outputs, each cleared by reset:
  - grant_count0: increments on each grant to port 0; saturates at 32'hFFFFFFFF.
  - grant_count1: increments on each grant to port 1; saturates at 32'hFFFFFFFF.
  - conflict_count: increments each IDLE cycle in which both requesters are pending; saturates at 32'hFFFFFFFF.
- MEM_ARB_PERF_EN undefined: these ports and their counters are absent. Arbitration behaviour is identical in both cases.

## Test plan
- Single read: req0_msg=1, addr 0x040; memory replies msg 2, addr 0x040, data 0xDEADBEEF 3 cycles later → resp0 = (2, 0x040, 0xDEADBEEF) for 1 cycle; grant 01→00; resp1 stays 0 throughout.
- Simultaneous requests after reset: req0 addr 0x010, req1 addr 0x020 → port 0 served first, port 1 granted at edge M+2. With MEM_ARB_PERF_EN, grant_count0 = 1, grant_count1 = 1, conflict_count ≥ 1.
- Round-robin: both requesters continuously re-request for 6 transactions → grant sequence 01, 10, 01, 10, 01, 10.
- Stray response: in BUSY for addr 0x100, memory presents msg 2 with addr 0x104 → ignored; state stays BUSY; a later response with addr 0x100 completes the transaction.
- Reset mid-transaction: assert reset in BUSY for port 1 → grant, busy and mem_msg are 0 before the next edge. After release, req0 alone is granted first (pointer = 0).
- Write pass-through: req1_msg=3, addr 0x7FC, data 0x12345678 → mem_* equals those values and is held until the memory response; no change on mem_* while req1_data toggles during BUSY.
